// File: rtl/fpga_msg_packer_pkg.sv
// fpga_msg_packer_pkg
// Shared definitions for the FPGA->PC message packer: packet sync nibbles,
// counter widths and the packer state encoding.
// Optional feature macro: FPGA_MSG_CHECKSUM_EN (adds the CHECKSUM state use).
package fpga_msg_packer_pkg;

    localparam logic [3:0] HDR_SYNC = 4'hA;
    localparam logic [3:0] TRL_SYNC = 4'h5;

    localparam int CNT_W = 12;   // n_col / n_row width, as carried in the packets
    localparam int FRM_W = 20;   // n_frame width; header carries the low 16 bits

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_PAYLOAD  = 3'd2,
        ST_TRAILER  = 3'd3,
        ST_CHECKSUM = 3'd4,
        ST_ERROR    = 3'd5
    } state_t;

endpackage

// File: rtl/fpga_msg_line_ctr.sv
// fpga_msg_line_ctr
// Column / row / frame counters for the message packer plus the protocol
// limit checks.
// Ports:
//   bus_clk, reset        clock, async active-high reset
//   clr_col               header emitted: restart the column count
//   pop                   payload pixel being taken from the upstream FIFO
//   pix_sof/eol/eof       flags of the pixel being taken
//   end_line, line_eof    trailer emitted; line_eof = that line closed a frame
//   n_col, n_row          current column count / row index
//   n_frame_lo            low 16 bits of the 20-bit frame counter
//   err_pix               the pixel being popped violates the line protocol
//   err_row               the trailer being emitted hits N_ROW_MAX without eof
module fpga_msg_line_ctr
    import fpga_msg_packer_pkg::*;
#(
    parameter int N_COL_MAX = 2048,
    parameter int N_ROW_MAX = 2064
) (
    input  logic             bus_clk,
    input  logic             reset,
    input  logic             clr_col,
    input  logic             pop,
    input  logic             pix_sof,
    input  logic             pix_eol,
    input  logic             pix_eof,
    input  logic             end_line,
    input  logic             line_eof,
    output logic [CNT_W-1:0] n_col,
    output logic [CNT_W-1:0] n_row,
    output logic [15:0]      n_frame_lo,
    output logic             err_pix,
    output logic             err_row
);

    localparam logic [CNT_W-1:0] COL_LIM  = CNT_W'(N_COL_MAX);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(N_ROW_MAX - 1);

    logic [FRM_W-1:0] n_frame;

    assign n_frame_lo = n_frame[15:0];

    // A pixel that would make n_col exceed the limit, an sof past the first
    // pixel of a line, or an eof that does not also end the line.
    assign err_pix = pop && ((n_col == COL_LIM) ||
                             (pix_sof && (n_col != '0)) ||
                             (pix_eof && !pix_eol));

    assign err_row = end_line && !line_eof && (n_row == ROW_LAST);

    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            n_col   <= '0;
            n_row   <= '0;
            n_frame <= '0;
        end else begin
            if (clr_col)
                n_col <= '0;
            else if (pop && !err_pix)
                n_col <= n_col + 1'b1;

            if (end_line) begin
                if (line_eof) begin
                    n_frame <= n_frame + 1'b1;
                    n_row   <= '0;
                end else begin
                    n_row <= n_row + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fpga_msg_packer.sv
// fpga_msg_packer
// Drains the processed pixel FIFO (FWFT) and frames each line into a
// header / payload / trailer packet for the FPGA->PC xillybus FIFO.
// Build option: define FPGA_MSG_CHECKSUM_EN to append an XOR checksum word
// after each trailer.
// Ports:
//   bus_clk, reset        clock, async active-high reset
//   enable                start new lines while high; a line in flight always completes
//   pix_empty, pix_ack    upstream FIFO empty / pop (pop is combinational)
//   pix_data, pix_sof, pix_eol, pix_eof   upstream pixel and framing flags
//   fpga_msg_full         downstream almost-full
//   fpga_msg_valid, fpga_msg              registered write strobe and word
//   error                 sticky protocol error, cleared only by reset
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | between lines; drops non-sof pixels before the frame's first header
//   HEADER   | emit {A, n_frame[15:0], n_row}
//   PAYLOAD  | one pixel per pop, until the eol pixel
//   TRAILER  | emit {5, 0, n_col}; advance row/frame
//   CHECKSUM | emit XOR of the line's payload (checksum build only)
//   ERROR    | absorbing; no pops, no words
module fpga_msg_packer
    import fpga_msg_packer_pkg::*;
#(
    parameter int XB_SIZE   = 32,
    parameter int FP_SIZE   = 32,
    parameter int N_COL_MAX = 2048,
    parameter int N_ROW_MAX = 2064
) (
    input  logic               bus_clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               pix_empty,
    output logic               pix_ack,
    input  logic [FP_SIZE-1:0] pix_data,
    input  logic               pix_sof,
    input  logic               pix_eol,
    input  logic               pix_eof,
    input  logic               fpga_msg_full,
    output logic               fpga_msg_valid,
    output logic [XB_SIZE-1:0] fpga_msg,
    output logic               error
);

    state_t           state;
    logic             line_eof;
    logic             go;
    logic             pop;
    logic             drop;
    logic             clr_col;
    logic             end_line;
    logic             err_pix;
    logic             err_row;
    logic [CNT_W-1:0] n_col;
    logic [CNT_W-1:0] n_row;
    logic [15:0]      n_frame_lo;
`ifdef FPGA_MSG_CHECKSUM_EN
    logic [31:0]      csum;
`endif

    assign go       = !fpga_msg_full && (state != ST_ERROR);
    assign pop      = go && !pix_empty && (state == ST_PAYLOAD);
    // n_row==0 in IDLE means this frame has not produced a header yet, so a
    // pixel without sof is leftover from an abandoned frame.
    assign drop     = go && !pix_empty && enable && (state == ST_IDLE) &&
                      (n_row == '0) && !pix_sof;
    assign pix_ack  = !reset && (pop || drop);
    assign clr_col  = go && (state == ST_HEADER);
    assign end_line = go && (state == ST_TRAILER);

    fpga_msg_line_ctr #(
        .N_COL_MAX (N_COL_MAX),
        .N_ROW_MAX (N_ROW_MAX)
    ) u_line_ctr (
        .bus_clk    (bus_clk),
        .reset      (reset),
        .clr_col    (clr_col),
        .pop        (pop),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .pix_eof    (pix_eof),
        .end_line   (end_line),
        .line_eof   (line_eof),
        .n_col      (n_col),
        .n_row      (n_row),
        .n_frame_lo (n_frame_lo),
        .err_pix    (err_pix),
        .err_row    (err_row)
    );

    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            fpga_msg_valid <= 1'b0;
            fpga_msg       <= '0;
            error          <= 1'b0;
            line_eof       <= 1'b0;
`ifdef FPGA_MSG_CHECKSUM_EN
            csum           <= '0;
`endif
        end else begin
            fpga_msg_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable && !pix_empty && !((n_row == '0) && !pix_sof))
                        state <= ST_HEADER;
                end
                ST_HEADER: begin
                    if (go) begin
                        fpga_msg_valid <= 1'b1;
                        fpga_msg       <= XB_SIZE'({HDR_SYNC, n_frame_lo, n_row});
`ifdef FPGA_MSG_CHECKSUM_EN
                        csum           <= '0;
`endif
                        state          <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (pop) begin
                        if (err_pix) begin
                            error <= 1'b1;
                            state <= ST_ERROR;
                        end else begin
                            fpga_msg_valid <= 1'b1;
                            fpga_msg       <= XB_SIZE'(pix_data);
`ifdef FPGA_MSG_CHECKSUM_EN
                            csum           <= csum ^ 32'(pix_data);
`endif
                            line_eof       <= pix_eof;
                            if (pix_eol)
                                state <= ST_TRAILER;
                        end
                    end
                end
                ST_TRAILER: begin
                    if (go) begin
                        fpga_msg_valid <= 1'b1;
                        fpga_msg       <= XB_SIZE'({TRL_SYNC, 16'h0, n_col});
                        if (err_row) begin
                            error <= 1'b1;
                            state <= ST_ERROR;
                        end else begin
`ifdef FPGA_MSG_CHECKSUM_EN
                            state <= ST_CHECKSUM;
`else
                            state <= ST_IDLE;
`endif
                        end
                    end
                end
`ifdef FPGA_MSG_CHECKSUM_EN
                ST_CHECKSUM: begin
                    if (go) begin
                        fpga_msg_valid <= 1'b1;
                        fpga_msg       <= XB_SIZE'(csum);
                        state          <= ST_IDLE;
                    end
                end
`endif
                ST_ERROR: begin
                    error <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_msg_packer.sv
module tb_fpga_msg_packer;

    localparam int XB_SIZE   = 32;
    localparam int FP_SIZE   = 32;
    localparam int N_COL_MAX = 2048;
    localparam int N_ROW_MAX = 2064;

    typedef struct packed {
        logic [31:0] d;
        logic        sof;
        logic        eol;
        logic        eof;
    } pix_t;

    logic               bus_clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               pix_empty;
    logic               pix_ack;
    logic [FP_SIZE-1:0] pix_data;
    logic               pix_sof;
    logic               pix_eol;
    logic               pix_eof;
    logic               fpga_msg_full;
    logic               fpga_msg_valid;
    logic [XB_SIZE-1:0] fpga_msg;
    logic               error;

    pix_t        fifo[$];
    logic [31:0] exp_q[$];
    int          checks;
    int          failures;
    int          cyc;
    int          hold_until;
    bit          throttle_en;
    bit          starve_en;
    int          m_frame;
    int          m_row;
    logic [31:0] d[$];
    logic [31:0] d2[$];
    int          nl;
    int          ln;

    always #5 bus_clk = ~bus_clk;

    fpga_msg_packer #(
        .XB_SIZE   (XB_SIZE),
        .FP_SIZE   (FP_SIZE),
        .N_COL_MAX (N_COL_MAX),
        .N_ROW_MAX (N_ROW_MAX)
    ) dut (
        .bus_clk        (bus_clk),
        .reset          (reset),
        .enable         (enable),
        .pix_empty      (pix_empty),
        .pix_ack        (pix_ack),
        .pix_data       (pix_data),
        .pix_sof        (pix_sof),
        .pix_eol        (pix_eol),
        .pix_eof        (pix_eof),
        .fpga_msg_full  (fpga_msg_full),
        .fpga_msg_valid (fpga_msg_valid),
        .fpga_msg       (fpga_msg),
        .error          (error)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %08h, expected %08h", name, act, req);
        end
    endfunction

    task automatic tick();
        @(posedge bus_clk);
        #2;
    endtask

    task automatic push_pix(input logic [31:0] v, input bit sof, input bit eol, input bit eof);
        pix_t p;
        p.d = v; p.sof = sof; p.eol = eol; p.eof = eof;
        fifo.push_back(p);
    endtask

    // Reference packet for a clean line: header, payload, trailer with the
    // pixel count, optional XOR checksum; then advance the row/frame position.
    task automatic model_line(input logic [31:0] v[$], input bit eof);
        logic [31:0] x;
        x = 32'h0;
        exp_q.push_back({4'hA, 16'(m_frame), 12'(m_row)});
        foreach (v[i]) begin
            exp_q.push_back(v[i]);
            x = x ^ v[i];
        end
        exp_q.push_back({4'h5, 16'h0, 12'(v.size())});
`ifdef FPGA_MSG_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        if (eof) begin
            m_frame = (m_frame + 1) % (1 << 20);
            m_row   = 0;
        end else begin
            m_row = m_row + 1;
        end
    endtask

    // A line that faults at pixel index k: header plus the k good pixels only.
    task automatic model_err(input logic [31:0] v[$], input int k);
        exp_q.push_back({4'hA, 16'(m_frame), 12'(m_row)});
        for (int i = 0; i < k; i++) exp_q.push_back(v[i]);
    endtask

    task automatic feed_line(input logic [31:0] v[$], input bit sof, input bit eof);
        foreach (v[i])
            push_pix(v[i], sof && (i == 0), i == v.size() - 1, eof && (i == v.size() - 1));
    endtask

    task automatic send_line(input logic [31:0] v[$], input bit sof, input bit eof);
        model_line(v, eof);
        feed_line(v, sof, eof);
    endtask

    task automatic rand_line(output logic [31:0] v[$], input int n);
        v.delete();
        repeat (n) v.push_back($urandom);
    endtask

    task automatic wait_drain(input int budget, input string name, input bit need_fifo_empty);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || (need_fifo_empty && fifo.size() != 0)) && k < budget) begin
            tick();
            k++;
        end
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0 || (need_fifo_empty && fifo.size() != 0)) begin
            failures++;
            $display("FAIL drain_%s: %0d words and %0d pixels outstanding, expected none",
                     name, exp_q.size(), fifo.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_fifo_le(input int n, input string name);
        int k;
        k = 0;
        while (fifo.size() > n && k < 500) begin
            tick();
            k++;
        end
        if (fifo.size() > n) begin
            checks++;
            failures++;
            $display("FAIL %s: %0d pixels still queued, expected <= %0d", name, fifo.size(), n);
        end
    endtask

    task automatic quiet_window(input int n, input string name);
        int acks;
        int vals;
        acks = 0;
        vals = 0;
        repeat (n) begin
            @(negedge bus_clk);
            if (pix_ack) acks++;
            if (fpga_msg_valid) vals++;
        end
        check({name, "_ack_count"}, acks, 0);
        check({name, "_valid_count"}, vals, 0);
    endtask

    task automatic do_reset(input string name);
        @(posedge bus_clk);
        #3;
        reset = 1'b1;
        #1;
        check({name, "_valid"}, {31'h0, fpga_msg_valid}, 32'h0);
        check({name, "_msg"}, fpga_msg, 32'h0);
        check({name, "_error"}, {31'h0, error}, 32'h0);
        check({name, "_ack"}, {31'h0, pix_ack}, 32'h0);
        exp_q.delete();
        m_frame = 0;
        m_row   = 0;
        repeat (2) @(posedge bus_clk);
        #3;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; hold_until = 0;
        throttle_en = 0; starve_en = 0; m_frame = 0; m_row = 0;
        reset = 1'b1; enable = 1'b0; fpga_msg_full = 1'b0;
        pix_empty = 1'b1; pix_data = '0; pix_sof = 1'b0; pix_eol = 1'b0; pix_eof = 1'b0;

        fork
            begin : feeder
                bit acked;
                forever begin
                    @(negedge bus_clk);
                    acked = pix_ack;
                    @(posedge bus_clk);
                    #1;
                    if (acked && fifo.size() > 0) void'(fifo.pop_front());
                    cyc++;
                    fpga_msg_full = (cyc < hold_until) || (throttle_en && $urandom_range(0, 3) == 0);
                    if (fifo.size() > 0 && !(starve_en && $urandom_range(0, 2) == 0)) begin
                        pix_empty = 1'b0;
                        pix_data  = fifo[0].d;
                        pix_sof   = fifo[0].sof;
                        pix_eol   = fifo[0].eol;
                        pix_eof   = fifo[0].eof;
                    end else begin
                        pix_empty = 1'b1;
                        pix_sof   = 1'b0;
                        pix_eol   = 1'b0;
                        pix_eof   = 1'b0;
                    end
                end
            end
            begin : monitor
                bit prev_full;
                logic [31:0] w;
                prev_full = 1'b0;
                forever begin
                    @(negedge bus_clk);
                    if (reset) begin
                        prev_full = 1'b0;
                    end else begin
                        if (fpga_msg_valid) begin
                            if (exp_q.size() == 0) begin
                                checks++;
                                failures++;
                                $display("FAIL unexpected_word: got %08h, expected no word", fpga_msg);
                            end else begin
                                w = exp_q.pop_front();
                                check("msg_word", fpga_msg, w);
                            end
                        end
                        if (prev_full) check("valid_after_full", {31'h0, fpga_msg_valid}, 32'h0);
                        if (fpga_msg_full) check("ack_while_full", {31'h0, pix_ack}, 32'h0);
                        prev_full = fpga_msg_full;
                    end
                end
            end
            begin : watchdog
                #2000000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // reset values
        #23;
        check("rst_valid", {31'h0, fpga_msg_valid}, 32'h0);
        check("rst_msg", fpga_msg, 32'h0);
        check("rst_error", {31'h0, error}, 32'h0);
        check("rst_ack", {31'h0, pix_ack}, 32'h0);
        @(posedge bus_clk);
        #3;
        reset = 1'b0;
        tick();

        // disabled with a pixel waiting: nothing popped, nothing emitted
        d = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        feed_line(d, 1, 0);
        quiet_window(20, "disabled");
        check("disabled_pixels_held", fifo.size(), 4);

        // basic 4-pixel line, 1.0 .. 4.0
        model_line(d, 0);
        enable = 1'b1;
        wait_drain(200, "basic", 1);

        // frame boundary: row 1, row 2 with eof, then frame 1 row 0
        rand_line(d, 2); send_line(d, 0, 0);
        rand_line(d, 3); send_line(d, 0, 1);
        rand_line(d, 2); send_line(d, 1, 0);
        wait_drain(300, "frames", 1);

        // almost-full held for 5 cycles mid-payload
        rand_line(d, 12); send_line(d, m_row == 0, 0);
        wait_fifo_le(8, "hold_start");
        hold_until = cyc + 6;
        wait_drain(300, "hold", 1);

        // enable dropped mid-line: line still completes, then idles
        rand_line(d, 10); send_line(d, m_row == 0, 0);
        wait_fifo_le(6, "drop_start");
        enable = 1'b0;
        rand_line(d2, 3);
        feed_line(d2, m_row == 0, 0);
        wait_drain(300, "enable_drop", 0);
        quiet_window(15, "idle_disabled");
        check("idle_pixels_held", fifo.size(), 3);
        model_line(d2, 0);
        enable = 1'b1;
        wait_drain(300, "resume", 1);

        // random lines with throttling, starvation and junk before each new frame
        throttle_en = 1;
        starve_en   = 1;
        for (int f = 0; f < 4; f++) begin
            nl = $urandom_range(1, 4);
            if (m_row == 0) begin
                push_pix($urandom, 0, 0, 0);
                push_pix($urandom, 0, 1, 0);
            end
            for (int l = 0; l < nl; l++) begin
                ln = $urandom_range(1, 10);
                rand_line(d, ln);
                send_line(d, m_row == 0, l == nl - 1);
            end
        end
        wait_drain(4000, "random", 1);
        throttle_en = 0;
        starve_en   = 0;
        check("error_after_random", {31'h0, error}, 32'h0);

        // async reset mid-payload; leftovers are dropped, next header is frame 0 row 0
        rand_line(d, 20); send_line(d, m_row == 0, 0);
        wait_fifo_le(12, "reset_start");
        do_reset("mid_reset");
        rand_line(d, 4); send_line(d, 1, 0);
        wait_drain(300, "after_reset", 1);

        // N_COL_MAX+1 pixels: header + N_COL_MAX words, then ERROR
        rand_line(d, N_COL_MAX + 1);
        model_err(d, N_COL_MAX);
        feed_line(d, 0, 0);
        wait_drain(6000, "col_overflow", 1);
        repeat (5) tick();
        check("col_overflow_error", {31'h0, error}, 32'h1);
        push_pix(32'h12345678, 1, 1, 0);
        repeat (10) tick();
        check("error_no_pop", fifo.size(), 1);
        check("error_sticky", {31'h0, error}, 32'h1);
        do_reset("err_reset");
        d = '{32'h12345678};
        model_line(d, 0);
        wait_drain(200, "after_err_reset", 1);
        check("error_cleared", {31'h0, error}, 32'h0);

        // sof on the second pixel of a line
        do_reset("pre_sof");
        d = '{32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003};
        model_err(d, 1);
        push_pix(d[0], 1, 0, 0);
        push_pix(d[1], 1, 0, 0);
        push_pix(d[2], 0, 1, 0);
        wait_drain(200, "sof_err", 0);
        check("sof_error", {31'h0, error}, 32'h1);

        // eof without eol
        do_reset("pre_eof");
        d = '{32'hBBBB0001, 32'hBBBB0002, 32'hBBBB0003};
        model_err(d, 1);
        push_pix(d[0], 1, 0, 0);
        push_pix(d[1], 0, 0, 1);
        push_pix(d[2], 0, 1, 0);
        wait_drain(200, "eof_err", 0);
        check("eof_error", {31'h0, error}, 32'h1);

        // recover and send a clean frame-closing line
        do_reset("final");
        rand_line(d, 5); send_line(d, 1, 1);
        rand_line(d, 3); send_line(d, 1, 0);
        wait_drain(300, "final", 1);
        check("final_error", {31'h0, error}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
